// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Default-width payload; the stage itself derives a width-matched copy.
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } pipe_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter, cleared only by reset.
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with two-entry skid buffer and flush.
// Perf counters are present when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          INSTR_W   = 32,
  parameter int          PC_W      = 64,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } payload_t;

  localparam payload_t NOP_PAYLOAD = '{
    instr: INSTR_W'(NOP_INSTR),
    pc:    '0
  };

  pipe_state_t state_q, state_d;
  payload_t    main_q, main_d;
  payload_t    skid_q, skid_d;
  payload_t    in_pl;
  logic        out_valid_q, in_ready_q;
  logic        accept, emit;

  assign in_pl  = '{instr: in_instr, pc: in_pc};
  assign accept = in_valid & in_ready_q;
  assign emit   = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_PAYLOAD;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_pl;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_d = in_pl;
          end else if (emit) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_d  = in_pl;
            state_d = TWO;
          end
        end
        TWO: begin
          if (emit) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_PAYLOAD;
        end
      endcase
    end
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= NOP_PAYLOAD;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid_q & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid_q),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg.
// Exercises the perf counters when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_STAGE_PERF_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;
`endif

  pipe_stage_reg #(.CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  pipe_payload_t q[$];
  int n_vec  = 0;
  int n_miss = 0;
  int n_emit = 0;
  bit last_acc;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; checks, updates the model, steps one cycle.
  task automatic tick();
    bit acc, emt;
    check("ovld", out_valid, q.size() != 0);
    check("irdy", in_ready, q.size() < 2);
    if (out_valid && q.size() != 0) begin
      check("instr", out_instr, q[0].instr);
      check("pc", out_pc, q[0].pc);
    end
    acc = in_valid && in_ready;
    emt = out_valid && out_ready;
    if (emt && q.size() != 0) begin
      void'(q.pop_front());
      n_emit++;
    end
    if (flush) q.delete();
    else if (acc) q.push_back('{instr: in_instr, pc: in_pc});
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] p);
    bit done = 0;
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = p;
    for (int k = 0; k < 8 && !done; k++) begin
      tick();
      done = last_acc;
    end
    if (!done) check("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    int e0;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ovld", out_valid, 0);
    check("rst_irdy", in_ready, 1);
    check("rst_instr", out_instr, 64'h13);
    check("rst_pc", out_pc, 0);
    reset = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    check("rst_stall", stall_cnt, 0);
    check("rst_bubble", bubble_cnt, 0);
    repeat (3) tick();
    check("bubble3", bubble_cnt, 3);
    push(32'hA0, 64'h100);
    repeat (20) tick();
    check("stall_sat", stall_cnt, 15);
    check("bubble4", bubble_cnt, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_stall", stall_cnt, 15);
    check("flush_bubble", bubble_cnt, 4);
`endif

    // Fill to two entries, then reset asynchronously mid-cycle.
    push(32'h11, 64'h40);
    push(32'h22, 64'h44);
    check("two_irdy", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_ovld", out_valid, 0);
    check("arst_irdy", in_ready, 1);
    check("arst_instr", out_instr, 64'h13);
    check("arst_pc", out_pc, 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Back-to-back stream.
    e0 = n_emit;
    for (int i = 0; i < 8; i++) push(32'(i), 64'(4 * i));
    tick();
    check("stream_emits", n_emit - e0, 8);

    // Backpressure: A, B accepted, C held upstream.
    out_ready = 1'b0;
    push(32'hA, 64'hA0);
    push(32'hB, 64'hB0);
    in_valid = 1'b1; in_instr = 32'hC; in_pc = 64'hC0;
    repeat (3) tick();
    check("bp_irdy", in_ready, 0);
    check("bp_hold", out_instr, 64'hA);
    out_ready = 1'b1;
    e0 = n_emit;
    push(32'hC, 64'hC0);
    repeat (2) tick();
    check("bp_emits", n_emit - e0, 3);

    // Flush while full with a new input offered.
    out_ready = 1'b0;
    push(32'h51, 64'h510);
    push(32'h52, 64'h520);
    in_valid = 1'b1; in_instr = 32'hDEAD; in_pc = 64'hBEEF;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_ovld", out_valid, 0);
    check("fl_instr", out_instr, 64'h13);
    check("fl_pc", out_pc, 0);
    check("fl_irdy", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      flush     = ($urandom_range(99) == 0);
      in_instr  = $urandom;
      in_pc     = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
